// File: rtl/pic_gen_pkg.sv
// Shared constants and helpers for the pic_gen interrupt controller.
// No logic of its own; register map, field positions, priority rotation helper.
// Imported by pic_gen and pic_gen_prio.
package pic_gen_pkg;

    // Register map (3-bit address space)
    localparam logic [2:0] ADDR_IMR  = 3'd0;
    localparam logic [2:0] ADDR_TRIG = 3'd1;
    localparam logic [2:0] ADDR_CTRL = 3'd2;
    localparam logic [2:0] ADDR_EOI  = 3'd3;
    localparam logic [2:0] ADDR_IRR  = 3'd4;
    localparam logic [2:0] ADDR_ISR  = 3'd5;

    // CTRL fields
    localparam int CTRL_ROTATE_BIT = 0;
    localparam int CTRL_AEOI_BIT   = 1;
    localparam int CTRL_VBASE_LSB  = 8;

    // EOI fields: line index lives in the low bits
    localparam int EOI_SPECIFIC_BIT = 8;

    // Line occupying priority rank 'rank' (0 = highest). Rotating mode puts
    // the pointer line on top and walks upward modulo n.
    function automatic int rot_index(input int rank, input int ptr,
                                     input logic rotate, input int n);
        return rotate ? (rank + ptr) % n : rank;
    endfunction

endpackage

// File: rtl/pic_gen_prio.sv
// Combinational priority resolver: best eligible request and top in-service line.
// Latency: zero cycles (pure combinational).
// Backpressure: none; outputs follow inputs every cycle.
//
// Ports: irr/imr/isr request, mask and in-service vectors; ptr/rotate select
// the priority order; cand_vld/cand_id give the highest unmasked request that
// outranks every in-service line; isr_vld/isr_id give the highest in-service line.
module pic_gen_prio
    import pic_gen_pkg::*;
#(
    parameter int N_IRQ = 8,
    parameter int ID_W  = $clog2(N_IRQ)
) (
    input  logic [N_IRQ-1:0] irr,
    input  logic [N_IRQ-1:0] imr,
    input  logic [N_IRQ-1:0] isr,
    input  logic [ID_W-1:0]  ptr,
    input  logic             rotate,
    output logic             cand_vld,
    output logic [ID_W-1:0]  cand_id,
    output logic             isr_vld,
    output logic [ID_W-1:0]  isr_id
);

    // Walk ranks from highest to lowest. Once an in-service line is seen, no
    // lower-ranked request may win; a line that is itself in service is
    // checked first so it can never nest on top of itself.
    always_comb begin
        logic [ID_W-1:0] line;
        cand_vld = 1'b0;
        cand_id  = '0;
        isr_vld  = 1'b0;
        isr_id   = '0;
        line     = '0;
        for (int r = 0; r < N_IRQ; r++) begin
            line = ID_W'(rot_index(r, int'(ptr), rotate, N_IRQ));
            if (!isr_vld && isr[line]) begin
                isr_vld = 1'b1;
                isr_id  = line;
            end
            if (!isr_vld && !cand_vld && irr[line] && !imr[line]) begin
                cand_vld = 1'b1;
                cand_id  = line;
            end
        end
    end

endmodule

// File: rtl/pic_gen.sv
// Parametrised programmable interrupt controller with nested fixed/rotating priority.
// Latency: IRR set -> INT one cycle; INTA -> VEC/VEC_VALID next cycle; RD -> RDATA next cycle.
// Backpressure: none; INTA and register strobes are accepted every cycle.
//
// Ports: CLK/RESET (async, active high); IRQ request lines; ADDR/WDATA/WR/RD/RDATA
// register bus; INT to the CPU; INTA acknowledge strobe; VEC/VEC_VALID vector return.
module pic_gen
    import pic_gen_pkg::*;
#(
    parameter int N_IRQ  = 8,
    parameter int ID_W   = $clog2(N_IRQ),
    parameter int VEC_W  = 8,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [N_IRQ-1:0]  IRQ,
    input  logic [2:0]        ADDR,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              WR,
    input  logic              RD,
    output logic [DATA_W-1:0] RDATA,
    output logic              INT,
    input  logic              INTA,
    output logic [VEC_W-1:0]  VEC,
    output logic              VEC_VALID
);

    localparam logic [N_IRQ-1:0] ONE = N_IRQ'(1);

    logic [N_IRQ-1:0] imr, trig, irr, isr, irq_prev;
    logic             rotate, aeoi;
    logic [VEC_W-1:0] vbase;
    logic [ID_W-1:0]  ptr;

    logic             cand_vld, top_isr_vld;
    logic [ID_W-1:0]  cand_id, top_isr_id;
    logic             ack_isr_vld_unused;
    logic [ID_W-1:0]  ack_isr_id_unused;
    logic             eoi_cand_vld_unused;
    logic [ID_W-1:0]  eoi_cand_id_unused;
    logic             wdata_unused;

    logic             wr_eoi, eoi_hit, ack_real;
    logic [ID_W-1:0]  eoi_line, eoi_id;
    logic [N_IRQ-1:0] eoi_clr, ack_mask, irr_nxt, isr_nxt;
    logic [ID_W-1:0]  ptr_nxt;
    logic [VEC_W-1:0] vec_nxt;
    logic [DATA_W-1:0] rd_val;

    // Only some WDATA bits are stored; fold the rest so they are visibly consumed.
    assign wdata_unused = ^WDATA;

    function automatic logic [ID_W-1:0] next_line(input logic [ID_W-1:0] id);
        return ID_W'((int'(id) + 1) % N_IRQ);
    endfunction

    // Acknowledge / INT resolver on the live request state.
    pic_gen_prio #(.N_IRQ(N_IRQ), .ID_W(ID_W)) u_ack_prio (
        .irr      (irr),
        .imr      (imr),
        .isr      (isr),
        .ptr      (ptr),
        .rotate   (rotate),
        .cand_vld (cand_vld),
        .cand_id  (cand_id),
        .isr_vld  (ack_isr_vld_unused),
        .isr_id   (ack_isr_id_unused)
    );

    // Second resolver only tracks in-service ordering for non-specific EOI.
    pic_gen_prio #(.N_IRQ(N_IRQ), .ID_W(ID_W)) u_eoi_prio (
        .irr      ('0),
        .imr      ('1),
        .isr      (isr),
        .ptr      (ptr),
        .rotate   (rotate),
        .cand_vld (eoi_cand_vld_unused),
        .cand_id  (eoi_cand_id_unused),
        .isr_vld  (top_isr_vld),
        .isr_id   (top_isr_id)
    );

    always_comb begin
        wr_eoi   = WR && (ADDR == ADDR_EOI);
        eoi_line = WDATA[ID_W-1:0];
        eoi_hit  = 1'b0;
        eoi_id   = '0;
        if (wr_eoi) begin
            if (WDATA[EOI_SPECIFIC_BIT]) begin
                if ((int'(eoi_line) < N_IRQ) && isr[eoi_line]) begin
                    eoi_hit = 1'b1;
                    eoi_id  = eoi_line;
                end
            end else if (top_isr_vld) begin
                eoi_hit = 1'b1;
                eoi_id  = top_isr_id;
            end
        end
        eoi_clr = eoi_hit ? (ONE << eoi_id) : '0;

        // Acknowledge uses pre-write CTRL/IMR; a spurious INTA touches no state.
        ack_real = INTA && cand_vld;
        ack_mask = ack_real ? (ONE << cand_id) : '0;

        // Level lines mirror IRQ; edge lines latch rises, and a rise in the
        // acknowledge cycle survives the acknowledge clear.
        irr_nxt = (trig & IRQ) | (~trig & ((irr & ~ack_mask) | (IRQ & ~irq_prev)));

        // EOI clears first so the acknowledge set in the same cycle sticks.
        isr_nxt = (isr & ~eoi_clr) | (aeoi ? '0 : ack_mask);

        ptr_nxt = ptr;
        if (rotate && eoi_hit) begin
            ptr_nxt = next_line(eoi_id);
        end
        if (rotate && aeoi && ack_real) begin
            ptr_nxt = next_line(cand_id);
        end

        vec_nxt = vbase + (ack_real ? VEC_W'(cand_id) : VEC_W'(N_IRQ - 1));
    end

    always_comb begin
        rd_val = '0;
        case (ADDR)
            ADDR_IMR:  rd_val = DATA_W'(imr);
            ADDR_TRIG: rd_val = DATA_W'(trig);
            ADDR_CTRL: begin
                rd_val[CTRL_ROTATE_BIT]             = rotate;
                rd_val[CTRL_AEOI_BIT]               = aeoi;
                rd_val[CTRL_VBASE_LSB +: VEC_W]     = vbase;
            end
            ADDR_IRR:  rd_val = DATA_W'(irr);
            ADDR_ISR:  rd_val = DATA_W'(isr);
            default:   rd_val = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            imr       <= '1;
            trig      <= '0;
            rotate    <= 1'b0;
            aeoi      <= 1'b0;
            vbase     <= '0;
            irr       <= '0;
            isr       <= '0;
            ptr       <= '0;
            irq_prev  <= '0;
            INT       <= 1'b0;
            VEC       <= '0;
            VEC_VALID <= 1'b0;
            RDATA     <= '0;
        end else begin
            irq_prev  <= IRQ;
            irr       <= irr_nxt;
            isr       <= isr_nxt;
            ptr       <= ptr_nxt;
            // INT is forced low in the cycle after an acknowledge.
            INT       <= INTA ? 1'b0 : cand_vld;
            VEC_VALID <= INTA;
            if (INTA) begin
                VEC <= vec_nxt;
            end
            if (RD) begin
                RDATA <= rd_val;
            end
            if (WR) begin
                case (ADDR)
                    ADDR_IMR:  imr  <= WDATA[N_IRQ-1:0];
                    ADDR_TRIG: trig <= WDATA[N_IRQ-1:0];
                    ADDR_CTRL: begin
                        rotate <= WDATA[CTRL_ROTATE_BIT];
                        aeoi   <= WDATA[CTRL_AEOI_BIT];
                        vbase  <= WDATA[CTRL_VBASE_LSB +: VEC_W];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pic_gen.sv
// Self-checking bench for pic_gen: directed scenarios plus random traffic
// against a rank-based behavioural model of the controller.
module tb_pic_gen;

    localparam int N = 8;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  IRQ;
    logic [2:0]  ADDR;
    logic [31:0] WDATA;
    logic        WR, RD, INTA;
    logic [31:0] RDATA;
    logic        INT;
    logic [7:0]  VEC;
    logic        VEC_VALID;

    pic_gen #(.N_IRQ(8), .VEC_W(8), .DATA_W(32)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IRQ       (IRQ),
        .ADDR      (ADDR),
        .WDATA     (WDATA),
        .WR        (WR),
        .RD        (RD),
        .RDATA     (RDATA),
        .INT       (INT),
        .INTA      (INTA),
        .VEC       (VEC),
        .VEC_VALID (VEC_VALID)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_imr, m_trig, m_irr, m_isr, m_prev, m_vbase;
    logic        m_rot, m_aeoi;
    int          m_ptr;
    logic        e_int, e_vv;
    logic [7:0]  e_vec;
    logic [31:0] e_rdata;
    logic [7:0]  cur_irq;

    task automatic m_reset();
        m_imr = 8'hFF; m_trig = '0; m_irr = '0; m_isr = '0; m_prev = '0;
        m_vbase = '0; m_rot = 0; m_aeoi = 0; m_ptr = 0;
        e_int = 0; e_vv = 0; e_vec = '0; e_rdata = '0;
    endtask

    function automatic int m_rank(int i);
        return m_rot ? (i - m_ptr + N) % N : i;
    endfunction

    function automatic int m_top_isr();
        int best = -1;
        for (int i = 0; i < N; i++)
            if (m_isr[i] && (best < 0 || m_rank(i) < m_rank(best))) best = i;
        return best;
    endfunction

    function automatic int m_cand();
        int h = m_top_isr();
        int lim = (h < 0) ? N : m_rank(h);
        int best = -1;
        for (int i = 0; i < N; i++)
            if (m_irr[i] && !m_imr[i] && m_rank(i) < lim &&
                (best < 0 || m_rank(i) < m_rank(best))) best = i;
        return best;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return {24'b0, m_imr};
            3'd1: return {24'b0, m_trig};
            3'd2: return {16'b0, m_vbase, 6'b0, m_aeoi, m_rot};
            3'd4: return {24'b0, m_irr};
            3'd5: return {24'b0, m_isr};
            default: return 32'b0;
        endcase
    endfunction

    // One clock: drive at negedge, predict, advance, compare just after posedge.
    task automatic step(input logic [2:0] a, input logic [31:0] wd,
                        input logic wr_v, input logic rd_v, input logic inta_v);
        int c, h, ln, n_ptr;
        logic [7:0] n_irr, n_isr, n_imr, n_trig, n_vbase;
        logic n_rot, n_aeoi, n_int, n_vv;
        logic [7:0] n_vec;
        logic [31:0] n_rdata;
        IRQ = cur_irq; ADDR = a; WDATA = wd; WR = wr_v; RD = rd_v; INTA = inta_v;
        c = m_cand();
        h = m_top_isr();
        n_int = inta_v ? 1'b0 : (c >= 0);
        n_vv = inta_v;
        n_vec = e_vec;
        if (inta_v) n_vec = 8'((int'(m_vbase) + ((c >= 0) ? c : N - 1)) % 256);
        n_rdata = rd_v ? m_read(a) : e_rdata;
        n_isr = m_isr; n_ptr = m_ptr;
        if (wr_v && a == 3'd3) begin
            if (wd[8]) begin
                ln = int'(wd[2:0]);
                if (m_isr[ln]) begin
                    n_isr[ln] = 1'b0;
                    if (m_rot) n_ptr = (ln + 1) % N;
                end
            end else if (h >= 0) begin
                n_isr[h] = 1'b0;
                if (m_rot) n_ptr = (h + 1) % N;
            end
        end
        if (inta_v && c >= 0) begin
            if (!m_aeoi) n_isr[c] = 1'b1;
            if (m_aeoi && m_rot) n_ptr = (c + 1) % N;
        end
        for (int i = 0; i < N; i++)
            n_irr[i] = m_trig[i] ? cur_irq[i]
                     : ((m_irr[i] && !(inta_v && c == i)) || (cur_irq[i] && !m_prev[i]));
        n_imr = m_imr; n_trig = m_trig; n_rot = m_rot; n_aeoi = m_aeoi; n_vbase = m_vbase;
        if (wr_v) begin
            if (a == 3'd0) n_imr = wd[7:0];
            if (a == 3'd1) n_trig = wd[7:0];
            if (a == 3'd2) begin n_rot = wd[0]; n_aeoi = wd[1]; n_vbase = wd[15:8]; end
        end
        @(posedge CLK);
        m_irr = n_irr; m_isr = n_isr; m_ptr = n_ptr; m_prev = cur_irq;
        m_imr = n_imr; m_trig = n_trig; m_rot = n_rot; m_aeoi = n_aeoi; m_vbase = n_vbase;
        e_int = n_int; e_vv = n_vv; e_vec = n_vec; e_rdata = n_rdata;
        #1;
        check("int", INT, e_int);
        check("vec_valid", VEC_VALID, e_vv);
        if (e_vv) check("vec", VEC, e_vec);
        if (rd_v) check("rdata", RDATA, e_rdata);
        @(negedge CLK);
        WR = 0; RD = 0; INTA = 0;
    endtask

    task automatic idle();                                   step(3'd0, 0, 0, 0, 0); endtask
    task automatic wr(input logic [2:0] a, input logic [31:0] d); step(a, d, 1, 0, 0); endtask
    task automatic rd(input logic [2:0] a);                  step(a, 0, 0, 1, 0); endtask
    task automatic ack();                                    step(3'd0, 0, 0, 0, 1); endtask

    initial begin
        logic [2:0]  ra, wa;
        logic [31:0] wd;
        logic        do_wr, do_rd, do_ack;

        RESET = 1; IRQ = 0; ADDR = 0; WDATA = 0; WR = 0; RD = 0; INTA = 0; cur_irq = 0;
        m_reset();
        #1;
        check("rst_int", INT, 0);
        check("rst_vv", VEC_VALID, 0);
        check("rst_vec", VEC, 0);
        check("rst_rdata", RDATA, 0);
        repeat (2) @(negedge CLK);
        RESET = 0;

        // Edge line 3
        wr(3'd0, 32'h0);
        cur_irq = 8'h08; idle(); idle();
        check("t1_int", INT, 1);
        ack();
        check("t1_vec", VEC, 3);
        rd(3'd5); check("t1_isr", RDATA, 32'h08);
        rd(3'd4); check("t1_irr", RDATA, 32'h00);
        cur_irq = 0; wr(3'd3, 32'h0); idle();

        // Fixed priority nesting
        cur_irq = 8'h24; idle(); idle();
        ack(); check("t2_vec_a", VEC, 2);
        idle(); idle(); check("t2_nest", INT, 0);
        wr(3'd3, 32'h0); idle(); check("t2_int", INT, 1);
        ack(); check("t2_vec_b", VEC, 5);
        wr(3'd3, 32'h0); cur_irq = 0; idle();

        // Rotating + AEOI, all lines level pending
        wr(3'd1, 32'hFF); wr(3'd2, 32'h3);
        cur_irq = 8'hFF; idle(); idle();
        for (int k = 0; k < 9; k++) begin
            ack(); check("t3_vec", VEC, k % 8);
            idle();
        end
        rd(3'd5); check("t3_isr", RDATA, 0);

        // Spurious acknowledge
        wr(3'd2, 32'h2000);
        cur_irq = 8'h40; idle(); idle();
        cur_irq = 8'h00; idle();
        ack(); check("t4_vec", VEC, 8'h27);
        rd(3'd5); check("t4_isr", RDATA, 0);

        // Masked edge
        wr(3'd1, 32'h0); wr(3'd0, 32'h02);
        cur_irq = 8'h02; idle(); idle();
        check("t5_masked", INT, 0);
        rd(3'd4); check("t5_irr", RDATA, 32'h02);
        wr(3'd0, 32'h0); idle(); check("t5_int", INT, 1);

        // Reset in the cycle after INTA
        ack(); check("t6_vec", VEC, 8'h21);
        cur_irq = 0;
        RESET = 1; #1;
        check("t6_vv", VEC_VALID, 0);
        check("t6_int", INT, 0);
        check("t6_vec0", VEC, 0);
        m_reset();
        @(negedge CLK); RESET = 0;
        rd(3'd0); check("t6_imr", RDATA, 32'hFF);
        rd(3'd5); check("t6_isr", RDATA, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) cur_irq = cur_irq ^ 8'($urandom & $urandom);
            do_wr = ($urandom_range(0, 4) == 0);
            do_rd = ($urandom_range(0, 2) == 0);
            do_ack = e_int ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 30) == 0);
            wa = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 9) == 0) ? wa : 3'($urandom_range(0, 7));
            wd = $urandom;
            if (wa == 3'd0 && $urandom_range(0, 1) == 0) wd = wd & $urandom;
            if (!do_wr) begin
                step(ra, 32'h0, 1'b0, do_rd, do_ack);
            end else if (!do_rd || ra == wa) begin
                step(wa, wd, 1'b1, do_rd, do_ack);
            end else begin
                step(wa, wd, 1'b1, 1'b0, do_ack);
                step(ra, 32'h0, 1'b0, 1'b1, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
